cordic_vectoring: RTL and testbench
===================================

# cordic_vectoring

Vectoring-mode CORDIC engine, the inverse of the rotation-mode `cordic` core. It accepts a fixed-point Cartesian pair (x, y) in the same Q2.(WIDTH-2) format that `cordic` produces on `sin_out`/`cos_out`. It returns the four-quadrant angle atan2(y, x) and the vector magnitude. It is iterative: one micro-rotation per clock, with a valid/ready/done handshake matching the rest of the CORDIC datapath.

## Interface
- `WIDTH`, 32: width of every data port.
- `ITER`, WIDTH-2: number of micro-rotations; legal range 8..WIDTH-2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_in` in 1: request strobe, sampled only while `ready`=1.
- `x_in` in WIDTH: signed Q2.(WIDTH-2), |x| ≤ 1.0.
- `y_in` in WIDTH: signed Q2.(WIDTH-2), |y| ≤ 1.0.
- `ready` out 1: high in IDLE only.
- `angle_out` out WIDTH: signed Q3.(WIDTH-3) radians, range (-π, π].
- `mag_out` out WIDTH: unsigned-valued Q3.(WIDTH-3) magnitude.
- `done` out 1: one-cycle pulse, results valid.

## Operation
- States are IDLE → FOLD → ITER → (SCALE) → IDLE.
- **IDLE**: `ready`=1. If `valid_in`=1 at an edge, capture `x_in`/`y_in` sign-extended to WIDTH+2 internal bits and go to FOLD.
- **FOLD** (1 cycle): if x<0, negate x and y and set z0=+π (y≥0) or -π (y<0). Otherwise z0=0. Clear the iteration counter.
- **ITER** (ITER cycles), iteration i:
  - If y≥0: x+=y>>>i, y-=x>>>i, z+=atan[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=atan[i].
  - Both updates use the pre-iteration x and y. Shifts are arithmetic and truncating.
  - After i=ITER-1, go to SCALE if the gain-compensation feature is compiled in, else to IDLE with result load.
- **SCALE** (1 cycle): mag = x·(1/K), product truncated to Q3.(WIDTH-3).
- Result load:
  - `angle_out` = z truncated to WIDTH bits.
  - `mag_out` = x (or the scaled x) re-aligned to Q3.(WIDTH-3).
  - Pulse `done`. Outputs hold until the next result load.
- The internal WIDTH+2 bit width guarantees no overflow of x, y or z for legal inputs.
- Boundary conditions:
  - x=0, y=0: angle 0, mag 0.
  - x<0, y=0: angle +π, never -π.
  - Inputs outside ±1.0 give unspecified results but must not hang the FSM.
- `valid_in` while `ready`=0 is ignored, not queued.

## Timing
- Reset values: `angle_out`=0, `mag_out`=0, `done`=0, state IDLE, so `ready`=1 while in reset.
- Latency, counted from the edge that samples `valid_in` to the edge that raises `done`:
  - ITER+2 cycles without compensation.
  - ITER+3 cycles with compensation.
  - For the defaults this is 32 and 33.
- `ready` is decoded combinationally from state, so it is high in the cycle `done` is high. Back-to-back requests are accepted on the edge after `done`.
- Reset asserted mid-operation aborts immediately: `done` does not pulse and outputs return to 0.

## Configuration
- The macro is `CORDIC_VEC_GAIN_COMP_EN`.
- **Defined**: SCALE state present. `mag_out` is the true magnitude, approximately √(x²+y²).
- **Undefined**: SCALE state and multiplier are removed. `mag_out` is the raw magnitude times K≈1.64676, and latency drops by one cycle.

## Structure
- Shared package/include `cordic_pkg` holds:
  - the atan table, atan(2^-i) for i=0..31 in Q3.29;
  - the π constant (0x6487ED51);
  - the 1/K constant (0.607253 in Q1.31);
  - the state encodings.
- The rotation-mode `cordic` core uses the same table.
- One natural sub-module, `cordic_vec_fold`: combinational quadrant fold from (x, y) to (x', y', z0), unit-testable alone.

## Test plan
All angle checks allow ±8 LSB and all magnitude checks allow ±16 LSB. Compensation is on unless stated.

- Reset behaviour: `rst`=0 → `angle_out`=0, `mag_out`=0, `done`=0, `ready`=1.
- x=y=0x20000000 (0.5):
  - `angle_out`≈0x1921FB54 (π/4), `mag_out`≈0x16A09E66;
  - `done` exactly 33 cycles after acceptance;
  - without the macro: `mag_out`≈1.16443·2^29 at 32 cycles.
- x=0xC0000000 (-1.0), y=0 → `angle_out`≈0x6487ED51 (+π), `mag_out`≈0x20000000.
- x=0, y=0xE0000000 (-0.5) → `angle_out`≈0xCDBC0957 (-π/2), `mag_out`≈0x10000000. Also x=y=0 → both outputs 0.
- Handshake: hold `valid_in`=1 with changing data throughout a conversion. Only the first sample is used, and the second request is accepted the cycle after `done`.
- Reset mid-operation: drop `rst` at iteration 10, release, then issue x=0.5, y=0.5:
  - no `done` pulse for the aborted request;
  - the new result matches the π/4 case.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: atan(2^-i) table in Q3.29, pi, 1/K and FSM state encodings.
// Used by both the rotation-mode and vectoring-mode engines.
package cordic_pkg;

    localparam logic [31:0] PI_Q329    = 32'h6487ED51;
    localparam logic [31:0] INV_K_Q131 = 32'h4DBA76D4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FOLD  = 2'd1,
        ST_ITER  = 2'd2,
        ST_SCALE = 2'd3
    } cordic_state_t;

    // Entries are rounded to nearest; from i=10 on atan(2^-i) rounds to exactly 2^-i.
    function automatic logic [31:0] atan_q329(input logic [4:0] i);
        case (i)
            5'd0:    return 32'h1921FB54;
            5'd1:    return 32'h0ED63383;
            5'd2:    return 32'h07D6DD7E;
            5'd3:    return 32'h03FAB753;
            5'd4:    return 32'h01FF55BB;
            5'd5:    return 32'h00FFEAAE;
            5'd6:    return 32'h007FFD55;
            5'd7:    return 32'h003FFFAB;
            5'd8:    return 32'h001FFFF5;
            5'd9:    return 32'h000FFFFF;
            5'd30:   return 32'h00000000;
            5'd31:   return 32'h00000000;
            default: return 32'd1 << (5'd29 - i);
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_fold.sv
// Quadrant fold for vectoring CORDIC: maps the left half-plane onto the right
// half-plane and supplies the matching +/-pi angle seed.
module cordic_vec_fold
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] i_x,
    input  logic [WIDTH+1:0] i_y,
    output logic [WIDTH+1:0] o_x,
    output logic [WIDTH+1:0] o_y,
    output logic [WIDTH+1:0] o_z
);
    localparam logic [WIDTH+1:0] PI_ALIGNED = (WIDTH + 2)'(PI_Q329 >> (32 - WIDTH));

    logic w_x_neg;
    logic w_y_neg;

    assign w_x_neg = i_x[WIDTH+1];
    assign w_y_neg = i_y[WIDTH+1];

    assign o_x = w_x_neg ? -i_x : i_x;
    assign o_y = w_x_neg ? -i_y : i_y;
    // y = 0 on the negative x axis takes +pi so the result lands in (-pi, pi].
    assign o_z = !w_x_neg ? '0 : (w_y_neg ? -PI_ALIGNED : PI_ALIGNED);

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) and magnitude, one micro-rotation per clock.
// Define CORDIC_VEC_GAIN_COMP_EN to add the 1/K scaling state (true magnitude, +1 cycle latency).
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             ready,
    output logic [WIDTH-1:0] angle_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             done
);
    localparam int         IW   = WIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITER);

    cordic_state_t        r_state;
    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic signed [IW-1:0] r_z;
    logic [4:0]           r_iter;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_angle;
    logic [WIDTH-1:0]     r_mag;
    logic                 r_done;

    logic [IW-1:0]        w_fold_x;
    logic [IW-1:0]        w_fold_y;
    logic [IW-1:0]        w_fold_z;
    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_ys;
    logic signed [IW-1:0] w_atan;

    cordic_vec_fold #(
        .WIDTH (WIDTH)
    ) u_fold (
        .i_x (r_x),
        .i_y (r_y),
        .o_x (w_fold_x),
        .o_y (w_fold_y),
        .o_z (w_fold_z)
    );

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_atan = IW'(atan_q329(r_iter) >> (32 - WIDTH));

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [IW+32:0] w_prod;
    assign w_prod = (IW + 33)'(r_x) * (IW + 33)'($signed({1'b0, INV_K_Q131}));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_x     <= IW'($signed(x_in));
                        r_y     <= IW'($signed(y_in));
                        r_state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    r_x     <= w_fold_x;
                    r_y     <= w_fold_y;
                    r_z     <= w_fold_z;
                    r_zero  <= (r_x == '0) && (r_y == '0);
                    r_iter  <= '0;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    if (r_iter == LAST) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        r_state <= ST_SCALE;
`else
                        r_angle <= r_zero ? '0 : WIDTH'(r_z);
                        r_mag   <= WIDTH'(r_x >>> 1);
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        // Drive y toward zero; both updates use the pre-iteration x and y.
                        if (r_y[IW-1]) begin
                            r_x <= r_x - w_ys;
                            r_y <= r_y + w_xs;
                            r_z <= r_z - w_atan;
                        end else begin
                            r_x <= r_x + w_ys;
                            r_y <= r_y - w_xs;
                            r_z <= r_z + w_atan;
                        end
                        r_iter <= r_iter + 5'd1;
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                ST_SCALE: begin
                    r_angle <= r_zero ? '0 : WIDTH'(r_z);
                    r_mag   <= WIDTH'(w_prod >>> 32);
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign angle_out = r_angle;
    assign mag_out   = r_mag;
    assign done      = r_done;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: expected angle/magnitude come from real-valued
// atan2/sqrt, queued when a request is accepted and popped when done pulses.
module tb_cordic_vectoring;
    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH - 2;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT  = ITER + 3;
    localparam real GAIN = 1.0;
`else
    localparam int  LAT  = ITER + 2;
    localparam real GAIN = 1.6467602581210656;
`endif
    localparam real SC      = 536870912.0;
    localparam real Q30     = 1073741824.0;
    localparam real PI_R    = 3.141592653589793;
    localparam real ANG_TOL = 8.0;
    localparam real MAG_TOL = 16.0;
    localparam int  TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic [WIDTH-1:0] y_in = '0;
    logic             ready;
    logic [WIDTH-1:0] angle_out;
    logic [WIDTH-1:0] mag_out;
    logic             done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t_acc      = 0;

    typedef struct {
        real ang;
        real mag;
    } exp_t;
    exp_t sb[$];

    cordic_vectoring #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .ready     (ready),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real ang_err(input logic [31:0] got, input real expv);
        real d;
        d = real'($signed(got)) - expv;
        if (d > PI_R * SC) d = d - 2.0 * PI_R * SC;
        else if (d < -PI_R * SC) d = d + 2.0 * PI_R * SC;
        return (d < 0.0) ? -d : d;
    endfunction

    function automatic real mag_err(input logic [31:0] got, input real expv);
        real d;
        d = real'(got) - expv;
        return (d < 0.0) ? -d : d;
    endfunction

    task automatic push_expect(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        real  xr;
        real  yr;
        xr = real'($signed(x)) / Q30;
        yr = real'($signed(y)) / Q30;
        e.ang = (x == 0 && y == 0) ? 0.0 : $atan2(yr, xr) * SC;
        e.mag = $sqrt(xr * xr + yr * yr) * GAIN * SC;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input bit hold);
        push_expect(x, y);
        @(negedge clk);
        x_in = x;
        y_in = y;
        valid_in = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        if (!hold) valid_in = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cyc - t_acc;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (angle_out !== '0) begin mismatched++; $display("FAIL reset_angle: got %h, required 0", angle_out); end
        compared++; if (mag_out !== '0) begin mismatched++; $display("FAIL reset_mag: got %h, required 0", mag_out); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b, required 0", done); end
        compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b, required 1", ready); end
        $display("txn reset angle=%h mag=%h done=%b ready=%b", angle_out, mag_out, done, ready);
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_diag(input string name);
        int   lat;
        bit   to;
        exp_t e;
        send(32'h20000000, 32'h20000000, 1'b0);
        wait_done(lat, to);
        e = sb.pop_front();
        compared++; if (to || lat != LAT) begin mismatched++; $display("FAIL %s_latency: got %0d cycles (timeout=%0d), required %0d", name, lat, to, LAT); end
        compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL %s_angle: got %h, required ~%.1f", name, angle_out, e.ang); end
        compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL %s_mag: got %h, required ~%.1f", name, mag_out, e.mag); end
        $display("txn %s x=20000000 y=20000000 angle=%h mag=%h lat=%0d", name, angle_out, mag_out, lat);
        @(posedge clk); #1;
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL %s_done_pulse: got %b one cycle later, required 0", name, done); end
    endtask

    task automatic test_neg_x();
        int   lat;
        bit   to;
        exp_t e;
        send(32'hC0000000, 32'h00000000, 1'b0);
        wait_done(lat, to);
        e = sb.pop_front();
        compared++; if (to || lat != LAT) begin mismatched++; $display("FAIL negx_latency: got %0d (timeout=%0d), required %0d", lat, to, LAT); end
        compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL negx_angle: got %h, required ~%.1f", angle_out, e.ang); end
        compared++; if (angle_out[WIDTH-1] !== 1'b0) begin mismatched++; $display("FAIL negx_plus_pi: got %h, required positive +pi", angle_out); end
        compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL negx_mag: got %h, required ~%.1f", mag_out, e.mag); end
        $display("txn negx x=c0000000 y=0 angle=%h mag=%h lat=%0d", angle_out, mag_out, lat);
    endtask

    task automatic test_neg_y_and_zero();
        int   lat;
        bit   to;
        exp_t e;
        send(32'h00000000, 32'hE0000000, 1'b0);
        wait_done(lat, to);
        e = sb.pop_front();
        compared++; if (to) begin mismatched++; $display("FAIL negy_timeout: got no done in %0d cycles, required done", TIMEOUT); end
        compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL negy_angle: got %h, required ~%.1f", angle_out, e.ang); end
        compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL negy_mag: got %h, required ~%.1f", mag_out, e.mag); end
        $display("txn negy x=0 y=e0000000 angle=%h mag=%h lat=%0d", angle_out, mag_out, lat);

        send(32'h00000000, 32'h00000000, 1'b0);
        wait_done(lat, to);
        e = sb.pop_front();
        compared++; if (to) begin mismatched++; $display("FAIL zero_timeout: got no done in %0d cycles, required done", TIMEOUT); end
        compared++; if (angle_out !== '0) begin mismatched++; $display("FAIL zero_angle: got %h, required 0", angle_out); end
        compared++; if (mag_out !== '0) begin mismatched++; $display("FAIL zero_mag: got %h, required 0", mag_out); end
        $display("txn zero x=0 y=0 angle=%h mag=%h lat=%0d", angle_out, mag_out, lat);
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   to;
        exp_t e;
        send(32'h20000000, 32'hF0000000, 1'b1);
        lat = 0;
        to  = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cyc - t_acc;
                to  = 1'b0;
                break;
            end
            if (k == 5) begin
                compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL hs_busy_ready: got %b, required 0", ready); end
            end
            x_in = $urandom_range(32'h3FFFFFFF, 0);
            y_in = $urandom_range(32'h3FFFFFFF, 0) | 32'hC0000000;
        end
        e = sb.pop_front();
        compared++; if (to || lat != LAT) begin mismatched++; $display("FAIL hs_first_latency: got %0d (timeout=%0d), required %0d", lat, to, LAT); end
        compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL hs_first_angle: got %h, required ~%.1f", angle_out, e.ang); end
        compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL hs_first_mag: got %h, required ~%.1f", mag_out, e.mag); end
        compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL hs_ready_with_done: got %b, required 1", ready); end
        $display("txn hs_first x=20000000 y=f0000000 angle=%h mag=%h lat=%0d", angle_out, mag_out, lat);

        push_expect(32'h10000000, 32'h30000000);
        x_in = 32'h10000000;
        y_in = 32'h30000000;
        @(posedge clk); #1;
        t_acc = cyc;
        valid_in = 1'b0;
        wait_done(lat, to);
        e = sb.pop_front();
        compared++; if (to || lat != LAT) begin mismatched++; $display("FAIL hs_second_latency: got %0d (timeout=%0d), required %0d", lat, to, LAT); end
        compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL hs_second_angle: got %h, required ~%.1f", angle_out, e.ang); end
        compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL hs_second_mag: got %h, required ~%.1f", mag_out, e.mag); end
        $display("txn hs_second x=10000000 y=30000000 angle=%h mag=%h lat=%0d", angle_out, mag_out, lat);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen_done;
        send(32'h26666666, 32'h0CCCCCCC, 1'b0);
        e = sb.pop_back();
        seen_done = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        rst = 1'b0;
        #1;
        compared++; if (angle_out !== '0) begin mismatched++; $display("FAIL midrst_angle: got %h, required 0", angle_out); end
        compared++; if (mag_out !== '0) begin mismatched++; $display("FAIL midrst_mag: got %h, required 0", mag_out); end
        compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b, required 1", ready); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        compared++; if (seen_done !== 1'b0) begin mismatched++; $display("FAIL midrst_no_done: got done=1 for aborted request, required none"); end
        $display("txn midrst aborted angle=%h mag=%h ready=%b", angle_out, mag_out, ready);
        test_diag("post_rst");
    endtask

    task automatic test_random();
        int          lat;
        bit          to;
        exp_t        e;
        logic [31:0] xv;
        logic [31:0] yv;
        real         xr;
        real         yr;
        for (int n = 0; n < 8; n++) begin
            xv = '0;
            yv = '0;
            for (int r = 0; r < 50; r++) begin
                xv = $urandom_range(32'h70000000, 0) - 32'h38000000;
                yv = $urandom_range(32'h70000000, 0) - 32'h38000000;
                xr = real'($signed(xv)) / Q30;
                yr = real'($signed(yv)) / Q30;
                if (xr * xr + yr * yr > 0.0625) break;
            end
            send(xv, yv, 1'b0);
            wait_done(lat, to);
            e = sb.pop_front();
            compared++; if (to || lat != LAT) begin mismatched++; $display("FAIL rand%0d_latency: got %0d (timeout=%0d), required %0d", n, lat, to, LAT); end
            compared++; if (ang_err(angle_out, e.ang) > ANG_TOL) begin mismatched++; $display("FAIL rand%0d_angle: got %h, required ~%.1f", n, angle_out, e.ang); end
            compared++; if (mag_err(mag_out, e.mag) > MAG_TOL) begin mismatched++; $display("FAIL rand%0d_mag: got %h, required ~%.1f", n, mag_out, e.mag); end
            $display("txn rand%0d x=%h y=%h angle=%h mag=%h lat=%0d", n, xv, yv, angle_out, mag_out, lat);
        end
    endtask

    initial begin
        test_reset();
        test_diag("diag");
        test_neg_x();
        test_neg_y_and_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
